// File: rtl/conv_pkg.sv
// Shared types and constant tables for the sequenced 4x4 / 3x3 convolver.
// Kernels are stored with bit 8 as tap (0,0), row-major down to bit 0.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    localparam logic [3:0][8:0] KERNELS = {
        9'b111111111,
        9'b111000111,
        9'b000010111,
        9'b100110000
    };

    localparam logic [3:0][3:0] ORIGINS = {
        4'd5,
        4'd4,
        4'd1,
        4'd0
    };

    localparam int DEF_THRESH = 40;

    // Pixel offset of tap t relative to a window origin (4 pixels per row).
    function automatic logic [3:0] tap_off(input logic [3:0] t);
        case (t)
            4'd0:    tap_off = 4'd0;
            4'd1:    tap_off = 4'd1;
            4'd2:    tap_off = 4'd2;
            4'd3:    tap_off = 4'd4;
            4'd4:    tap_off = 4'd5;
            4'd5:    tap_off = 4'd6;
            4'd6:    tap_off = 4'd8;
            4'd7:    tap_off = 4'd9;
            4'd8:    tap_off = 4'd10;
            default: tap_off = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single shared multiply-accumulate step for a binary kernel tap.
// Purely combinational; the sequencer owns the accumulator register.
module conv_mac
    import conv_pkg::*;
#(
    parameter int PIX_W = 5,
    parameter int OUT_W = 9
) (
    input  logic             clear,
    input  logic [PIX_W-1:0] pixel,
    input  logic             kbit,
    input  logic [OUT_W-1:0] acc_in,
    output logic [OUT_W-1:0] acc_out
);

    // A binary kernel turns the multiply into a gated add.
    always_comb begin
        acc_out = (clear ? '0 : acc_in) + (kbit ? OUT_W'(pixel) : '0);
    end

endmodule

// File: rtl/conv_sequencer.sv
// Clocked convolution controller: buffers 16 pixels, then walks 4 windows
// x 9 taps through one MAC, registering each window sum and a threshold flag.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int PIX_W  = 5,
    parameter int OUT_W  = 9,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       m,
    input  logic             reload,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out0,
    output logic [OUT_W-1:0] out1,
    output logic [OUT_W-1:0] out2,
    output logic [OUT_W-1:0] out3,
    output logic             ans
);

    localparam int TOT_W = 11;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       pix_cnt;
    logic [1:0]       win_q;
    logic [3:0]       tap_q;
    logic [1:0]       mode_q;
    logic             buf_valid;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_next;
    logic [TOT_W-1:0] total_q;
    logic [TOT_W-1:0] tot_next;
    logic [PIX_W-1:0] buf_q [16];
    logic [3:0]       pix_idx;
    logic [8:0]       kmask;
    logic [3:0]       kidx;
    logic             kbit;
    logic             last_tap;

    assign last_tap = (tap_q == 4'd8);
    assign pix_idx  = ORIGINS[win_q] + tap_off(tap_q);
    assign kmask    = KERNELS[mode_q];
    assign kidx     = 4'd8 - tap_q;
    assign kbit     = kmask[kidx];

    conv_mac #(
        .PIX_W(PIX_W),
        .OUT_W(OUT_W)
    ) u_mac (
        .clear  (tap_q == 4'd0),
        .pixel  (buf_q[pix_idx]),
        .kbit   (kbit),
        .acc_in (acc_q),
        .acc_out(acc_next)
    );

    // Running total restarts with window 0 so no separate clear is needed.
    always_comb begin
        tot_next = (win_q == 2'd0 ? '0 : total_q) + TOT_W'(acc_next);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (reload || !buf_valid) ? LOAD : CALC;
            LOAD: if (pix_valid && pix_cnt == 4'd15) state_d = CALC;
            CALC: if (win_q == 2'd3 && last_tap) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        pix_ready = (state_q == LOAD);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

    // Pixel buffer; contents after reset are irrelevant since buf_valid drops.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && pix_valid) buf_q[pix_cnt] <= pix_in;
    end

    // Counters, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt   <= '0;
            win_q     <= '0;
            tap_q     <= '0;
            mode_q    <= '0;
            buf_valid <= 1'b0;
            acc_q     <= '0;
            total_q   <= '0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            ans       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= m;
                        pix_cnt <= '0;
                        win_q   <= '0;
                        tap_q   <= '0;
                    end
                end
                LOAD: begin
                    if (pix_valid) begin
                        pix_cnt <= pix_cnt + 4'd1;
                        if (pix_cnt == 4'd15) buf_valid <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q <= acc_next;
                    if (last_tap) begin
                        tap_q   <= '0;
                        win_q   <= win_q + 2'd1;
                        total_q <= tot_next;
                        unique case (win_q)
                            2'd0: out0 <= acc_next;
                            2'd1: out1 <= acc_next;
                            2'd2: out2 <= acc_next;
                            2'd3: begin
                                out3 <= acc_next;
                                ans  <= (tot_next > TOT_W'(THRESH));
                            end
                        endcase
                    end else begin
                        tap_q <= tap_q + 4'd1;
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: drivers push expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] m;
    logic       reload;
    logic [4:0] pix_in;
    logic       pix_valid;
    logic       pix_ready;
    logic       busy;
    logic       done;
    logic [8:0] out0, out1, out2, out3;
    logic       ans;

    conv_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .reload   (reload),
        .pix_in   (pix_in),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy     (busy),
        .done     (done),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .ans      (ans)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int e0;
        int e1;
        int e2;
        int e3;
        int ea;
        int dc;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [4:0] p [16];
    int         st_cyc;
    int         last_acc;
    int         rs;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int a, input int b, input int c, input int d,
                        input int an, input int dc);
        exp_t e;
        e.e0 = a; e.e1 = b; e.e2 = c; e.e3 = d; e.ea = an; e.dc = dc;
        q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending op");
            end else begin
                e = q.pop_front();
                chk("out0", int'(out0), e.e0);
                chk("out1", int'(out1), e.e1);
                chk("out2", int'(out2), e.e2);
                chk("out3", int'(out3), e.e3);
                chk("ans", int'(ans), e.ea);
                chk("done_cycle", cyc, e.dc);
            end
        end
    end

    // Issue start at a negedge; the following posedge accepts it.
    task automatic start_op(input logic [1:0] mm, input logic rl);
        start  = 1'b1;
        m      = mm;
        reload = rl;
        st_cyc = cyc;
        @(negedge clk);
        start  = 1'b0;
        m      = ~mm;
        reload = ~rl;
    endtask

    task automatic load(input bit gaps);
        int n = 0;
        int k = 0;
        while (n < 16 && k < 200) begin
            pix_valid = gaps ? (k[0] == 1'b0) : 1'b1;
            pix_in    = p[n];
            if (pix_valid && pix_ready) begin
                if (n == 15) last_acc = cyc + 1;
                n++;
            end
            @(negedge clk);
            k++;
        end
        pix_valid = 1'b0;
        chk("accepts", n, 16);
        chk("ready_after_load", int'(pix_ready), 0);
    endtask

    task automatic wait_done(output int ready_seen);
        int k = 0;
        ready_seen = 0;
        while (!done && k < 100) begin
            if (pix_ready) ready_seen++;
            @(negedge clk);
            k++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done within 100");
        end
        @(negedge clk);
    endtask

    int ex0 [3] = '{12, 36, 36};
    int ex1 [3] = '{15, 40, 42};
    int ex2 [3] = '{24, 52, 60};
    int ex3 [3] = '{27, 56, 66};

    initial begin
        rst = 1'b1; start = 1'b0; m = 2'd0; reload = 1'b0;
        pix_in = '0; pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out0", int'(out0), 0);
        chk("rst_out3", int'(out3), 0);
        chk("rst_ans", int'(ans), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Pixels 1..16, full kernel.
        for (int i = 0; i < 16; i++) p[i] = 5'(i + 1);
        start_op(2'd3, 1'b1);
        chk("busy_load", int'(busy), 1);
        load(1'b0);
        push(54, 63, 90, 99, 1, last_acc + 36);
        wait_done(rs);

        // Buffer reuse with the other three kernels.
        for (int k = 0; k < 3; k++) begin
            start_op(2'(k), 1'b0);
            push(ex0[k], ex1[k], ex2[k], ex3[k], 1, st_cyc + 37);
            wait_done(rs);
            chk("reuse_no_ready", rs, 0);
        end

        // Threshold boundary: total exactly 40, then 41.
        for (int i = 0; i < 16; i++) p[i] = 5'd0;
        p[5] = 5'd10;
        start_op(2'd3, 1'b1);
        load(1'b0);
        push(10, 10, 10, 10, 0, last_acc + 36);
        wait_done(rs);
        p[0] = 5'd1;
        start_op(2'd3, 1'b1);
        load(1'b0);
        push(11, 10, 10, 10, 1, last_acc + 36);
        wait_done(rs);

        // Max pixels with gapped valid.
        for (int i = 0; i < 16; i++) p[i] = 5'd31;
        start_op(2'd3, 1'b1);
        load(1'b1);
        push(279, 279, 279, 279, 1, last_acc + 36);
        wait_done(rs);

        // Start, m, reload and pix_valid churn during CALC and DONE.
        start_op(2'd3, 1'b0);
        push(279, 279, 279, 279, 1, st_cyc + 37);
        repeat (10) @(negedge clk);
        start = 1'b1; m = 2'd0; reload = 1'b1;
        pix_valid = 1'b1; pix_in = 5'd0;
        wait_done(rs);
        chk("ignore_no_ready", rs, 0);
        chk("idle_after_done", int'(busy), 0);
        start = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        start_op(2'd3, 1'b0);
        push(279, 279, 279, 279, 1, st_cyc + 37);
        wait_done(rs);

        // Reset mid-CALC clears results and invalidates the buffer.
        start_op(2'd2, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out0", int'(out0), 0);
        chk("mid_rst_out1", int'(out1), 0);
        chk("mid_rst_out2", int'(out2), 0);
        chk("mid_rst_out3", int'(out3), 0);
        chk("mid_rst_ans", int'(ans), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) p[i] = 5'(i + 1);
        start_op(2'd3, 1'b0);
        chk("reload_forced", int'(pix_ready), 1);
        load(1'b0);
        push(54, 63, 90, 99, 1, last_acc + 36);
        wait_done(rs);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1);
    end

endmodule
